proc_run_monitor: RTL
=====================

// Module: proc_run_monitor
// PURPOSE
//  Run controller and register-write checker for processor bring-up. Sits beside the processor top.
//  - Sequences processor reset and bounds run length to MAX_CYCLES.
//  - Compares the ordered stream of regfile writes against a loaded expected table.
//  - Reports pass/fail with cycle count, so benches only pulse start and wait for done.
// PARAMETERS
//  DATA_WIDTH    32   regfile write-data width
//  REG_W         5    regfile address width
//  NUM_CHECKS    8    expected-table depth; CHK_W = $clog2(NUM_CHECKS) (localparam)
//  RESET_CYCLES  1    cycles proc_reset is held after start (>=1)
//  MAX_CYCLES    200  RUN-state cycle budget (>=1); CYC_W = $clog2(MAX_CYCLES+1)
//  STOP_ON_OVF   1    1: overflow in RUN ends run with fail; 0: overflow ignored
// PORTS
//  clock             in   1           single clock, all logic posedge
//  reset             in   1           synchronous, active-high
//  start             in   1           begin run (accepted in IDLE or DONE)
//  exp_we            in   1           write expected-table entry (IDLE/DONE only)
//  exp_index         in   CHK_W       table entry index
//  exp_reg           in   REG_W       expected destination register
//  exp_data          in   DATA_WIDTH  expected write data
//  exp_count         in   CHK_W+1     number of valid entries; sampled on accepted start
//  ctrl_writeEnable  in   1           processor regfile write strobe
//  ctrl_writeReg     in   REG_W       processor regfile write address
//  data_writeReg     in   DATA_WIDTH  processor regfile write data
//  overflow          in   1           processor ALU overflow flag
//  proc_reset        out  1           reset to processor
//  running           out  1           high in RUN
//  done              out  1           high in DONE
//  pass              out  1           valid when done
//  fail_code         out  2           0 none, 1 mismatch, 2 timeout, 3 overflow
//  check_ptr         out  CHK_W+1     number of matched writes
//  cycle_count       out  CYC_W       RUN cycles elapsed
//  fail_data         out  DATA_WIDTH  offending write data (mismatch only, else 0)
// BEHAVIOUR
//  FSM: IDLE -> RESET -> RUN -> DONE. All outputs are registered.
//  - IDLE: proc_reset=1. On start, latch exp_count, clear status, go to RESET.
//  - RESET: proc_reset=1 for exactly RESET_CYCLES cycles, then go to RUN.
//  - RUN: proc_reset=0; cycle_count increments every cycle.
//  - DONE: proc_reset=1; status is held. On start, clear status and go to RESET (restart).
//  Start timing: start accepted at cycle t -> proc_reset low from t+RESET_CYCLES+1.
//  Reset values: state=IDLE, proc_reset=1, running=0, done=0, pass=0, fail_code=0, check_ptr=0,
//   cycle_count=0, fail_data=0. The expected table is NOT cleared by reset.
//  Reset mid-run: abort to IDLE next cycle with reset values.
//  Checking (RUN only; write events have ctrl_writeEnable=1 and ctrl_writeReg!=0; r0 writes ignored):
//  - Event matching table[check_ptr] (reg and data) -> check_ptr++.
//  - Mismatch -> DONE, fail_code=1, fail_data=data_writeReg.
//  - Event when check_ptr==latched count -> mismatch (unexpected extra write).
//  - check_ptr reaching a latched count > 0 -> DONE with pass=1.
//  - overflow=1 with STOP_ON_OVF=1 -> DONE, fail_code=3.
//  - cycle_count == MAX_CYCLES-1 with no other terminal event -> DONE:
//    pass=1 if latched count==0, else fail_code=2. RUN therefore lasts at most MAX_CYCLES cycles.
//  Terminal-event latency: an event sampled in RUN cycle k gives done=1, running=0 and status at k+1.
//  Priority on the same cycle: mismatch > final match (pass) > overflow > timeout.
//  exp_we outside IDLE/DONE is ignored. exp_index >= NUM_CHECKS is ignored.
//  exp_count > NUM_CHECKS is clamped to NUM_CHECKS.
// TESTING
//  1. Load 3 entries {r1=5, r2=7, r3=12}, exp_count=3, start; drive writes r1=5, r2=7, r3=12
//     -> done 1 cycle after the r3 write, pass=1, check_ptr=3, fail_code=0.
//  2. Same table; drive r1=5, then r2=8 -> done, pass=0, fail_code=1, fail_data=8, check_ptr=1.
//  3. exp_count=2, no writes, MAX_CYCLES=200 -> done exactly 200 cycles after proc_reset falls,
//     fail_code=2, cycle_count=199.
//  4. r0 write (data 0xDEAD) between matches -> ignored, pass still asserted.
//     overflow=1 mid-run -> fail_code=3.
//  5. Last match and overflow in the same cycle -> pass=1.
//     reset asserted mid-RUN -> IDLE, proc_reset=1, counters 0.
//  6. RESET_CYCLES=4: proc_reset stays high 4 cycles after start.
//     start in DONE restarts the run with a cleared status and the same table.

Source files
------------

// File: rtl/proc_run_monitor.sv
// Processor bring-up run controller: sequences proc_reset, bounds run length and checks regfile writes.
// Terminal status appears one cycle after the deciding RUN cycle. There is no backpressure; every write event is judged in the cycle it appears.
module proc_run_monitor #(
    parameter int DATA_WIDTH   = 32,
    parameter int REG_W        = 5,
    parameter int NUM_CHECKS   = 8,
    parameter int RESET_CYCLES = 1,
    parameter int MAX_CYCLES   = 200,
    parameter int STOP_ON_OVF  = 1,
    localparam int CHK_W = $clog2(NUM_CHECKS),
    localparam int CYC_W = $clog2(MAX_CYCLES + 1)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  exp_we,
    input  logic [CHK_W-1:0]      exp_index,
    input  logic [REG_W-1:0]      exp_reg,
    input  logic [DATA_WIDTH-1:0] exp_data,
    input  logic [CHK_W:0]        exp_count,
    input  logic                  ctrl_writeEnable,
    input  logic [REG_W-1:0]      ctrl_writeReg,
    input  logic [DATA_WIDTH-1:0] data_writeReg,
    input  logic                  overflow,
    output logic                  proc_reset,
    output logic                  running,
    output logic                  done,
    output logic                  pass,
    output logic [1:0]            fail_code,
    output logic [CHK_W:0]        check_ptr,
    output logic [CYC_W-1:0]      cycle_count,
    output logic [DATA_WIDTH-1:0] fail_data
);
    localparam int RST_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [CHK_W:0]     NUM_CHK_V = (CHK_W + 1)'(NUM_CHECKS);
    localparam logic [CHK_W:0]     ONE_PTR   = 1;
    localparam logic [CYC_W-1:0]   LAST_CYC  = CYC_W'(MAX_CYCLES - 1);
    localparam logic [CYC_W-1:0]   ONE_CYC   = 1;
    localparam logic [RST_W-1:0]   LAST_RST  = RST_W'(RESET_CYCLES - 1);
    localparam logic [RST_W-1:0]   ONE_RST   = 1;

    typedef enum logic [1:0] {S_IDLE, S_RESET, S_RUN, S_DONE} state_t;

    state_t                 state;
    logic [RST_W-1:0]       rst_cnt;
    logic [CHK_W:0]         exp_cnt;
    logic [REG_W-1:0]       tbl_reg  [NUM_CHECKS];
    logic [DATA_WIDTH-1:0]  tbl_data [NUM_CHECKS];

    logic [CHK_W-1:0]       cur_idx;
    logic                   wr_event;
    logic                   entry_ok;
    logic                   bad_write;
    logic                   final_match;
    logic                   ovf_stop;
    logic                   timeout;
    logic                   idle_like;

    // Once check_ptr reaches the latched count, any further write is an unexpected extra.
    always_comb begin
        cur_idx     = check_ptr[CHK_W-1:0];
        wr_event    = ctrl_writeEnable && (ctrl_writeReg != '0);
        entry_ok    = (check_ptr != exp_cnt)
                   && (tbl_reg[cur_idx] == ctrl_writeReg)
                   && (tbl_data[cur_idx] == data_writeReg);
        bad_write   = wr_event && !entry_ok;
        final_match = wr_event && entry_ok && ((check_ptr + ONE_PTR) == exp_cnt);
        ovf_stop    = overflow && (STOP_ON_OVF != 0);
        timeout     = (cycle_count == LAST_CYC);
        idle_like   = (state == S_IDLE) || (state == S_DONE);
    end

    // The expected table survives reset so it can be loaded once and reused across runs.
    always_ff @(posedge clock) begin
        if (exp_we && idle_like && ({1'b0, exp_index} < NUM_CHK_V)) begin
            tbl_reg[exp_index]  <= exp_reg;
            tbl_data[exp_index] <= exp_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= S_IDLE;
            rst_cnt     <= '0;
            exp_cnt     <= '0;
            proc_reset  <= 1'b1;
            running     <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            fail_code   <= 2'd0;
            check_ptr   <= '0;
            cycle_count <= '0;
            fail_data   <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state       <= S_RESET;
                        rst_cnt     <= '0;
                        exp_cnt     <= (exp_count > NUM_CHK_V) ? NUM_CHK_V : exp_count;
                        proc_reset  <= 1'b1;
                        running     <= 1'b0;
                        done        <= 1'b0;
                        pass        <= 1'b0;
                        fail_code   <= 2'd0;
                        check_ptr   <= '0;
                        cycle_count <= '0;
                        fail_data   <= '0;
                    end
                end
                S_RESET: begin
                    if (rst_cnt == LAST_RST) begin
                        state      <= S_RUN;
                        proc_reset <= 1'b0;
                        running    <= 1'b1;
                    end else begin
                        rst_cnt <= rst_cnt + ONE_RST;
                    end
                end
                S_RUN: begin
                    if (bad_write || final_match || ovf_stop || timeout) begin
                        state      <= S_DONE;
                        done       <= 1'b1;
                        running    <= 1'b0;
                        proc_reset <= 1'b1;
                    end
                    // Priority: mismatch, final match, overflow, timeout.
                    if (bad_write) begin
                        fail_code <= 2'd1;
                        fail_data <= data_writeReg;
                    end else if (final_match) begin
                        check_ptr <= check_ptr + ONE_PTR;
                        pass      <= 1'b1;
                    end else begin
                        if (wr_event) begin
                            check_ptr <= check_ptr + ONE_PTR;
                        end
                        if (ovf_stop) begin
                            fail_code <= 2'd3;
                        end else if (timeout) begin
                            pass      <= (exp_cnt == '0);
                            fail_code <= (exp_cnt == '0) ? 2'd0 : 2'd2;
                        end else begin
                            cycle_count <= cycle_count + ONE_CYC;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
